// File: rtl/draw_pkg.sv
// Shared drawing definitions for the sprite layer arbiter.
// Contents: screen geometry, coordinate/colour widths, the sprite record
// held in the shadow and active banks, and the arbiter FSM state type.
package draw_pkg;

  localparam int H_ACTIVE = 1440;
  localparam int V_ACTIVE = 900;
  localparam int X_W      = 11;
  localparam int Y_W      = 10;
  localparam int RGB_W    = 12;

  // One bit wider than the screen coordinates, so that x+SPR_W / y+SPR_H
  // for sprites hanging off the right or bottom edge cannot wrap to 0.
  localparam int XS_W = $clog2(H_ACTIVE) + 1;
  localparam int YS_W = $clog2(V_ACTIVE) + 1;

  typedef struct packed {
    logic [X_W-1:0]   x;
    logic [Y_W-1:0]   y;
    logic [RGB_W-1:0] rgb;
    logic             vis;
  } sprite_t;

  typedef enum logic {
    ST_ACCEPT = 1'b0,
    ST_COMMIT = 1'b1
  } state_t;

endpackage

// File: rtl/sprite_layer_arbiter_if.sv
// Sprite update port between game-logic requesters and the arbiter.
// Signals (requester i uses bit i / slice i):
//   upd_req  per-requester request, held until acked
//   upd_x    packed left edges,  [X_W*i +: X_W]
//   upd_y    packed top edges,   [Y_W*i +: Y_W]
//   upd_rgb  packed colours,     [RGB_W*i +: RGB_W]
//   upd_vis  per-requester visibility
//   upd_ack  one-hot ack, the shadow entry is written at the end of that cycle
// Modports: master = requester side, slave = arbiter side.
interface sprite_layer_arbiter_if
  import draw_pkg::*;
#(
  parameter int N_SPR = 4
) ();

  logic [N_SPR-1:0]       upd_req;
  logic [X_W*N_SPR-1:0]   upd_x;
  logic [Y_W*N_SPR-1:0]   upd_y;
  logic [RGB_W*N_SPR-1:0] upd_rgb;
  logic [N_SPR-1:0]       upd_vis;
  logic [N_SPR-1:0]       upd_ack;

  modport master (
    output upd_req, upd_x, upd_y, upd_rgb, upd_vis,
    input  upd_ack
  );

  modport slave (
    input  upd_req, upd_x, upd_y, upd_rgb, upd_vis,
    output upd_ack
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
// Ports:
//   req       in   N      request vector
//   ptr       in   PTR_W  highest-priority index this cycle (0..N-1)
//   grant     out  N      one-hot grant of the first request at or after ptr
//   next_ptr  out  PTR_W  index after the granted one (mod N); ptr when idle
module rr_arbiter #(
  parameter  int N     = 4,
  localparam int PTR_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [PTR_W-1:0] next_ptr
);

  logic             found;
  logic [PTR_W-1:0] idx;

  always_comb begin
    grant    = '0;
    next_ptr = ptr;
    found    = 1'b0;
    idx      = '0;
    for (int k = 0; k < N; k++) begin
      idx = PTR_W'((int'(ptr) + k) % N);
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        next_ptr   = (int'(idx) == N - 1) ? '0 : idx + 1'b1;
      end
    end
  end

endmodule

// File: rtl/sprite_layer_arbiter.sv
// Sprite layer arbiter for the 1440x900 VGA output stage.
// Requesters post sprite updates through a req/ack port; a round-robin
// arbiter serialises them into a shadow bank, which is copied to the active
// bank once per frame on the rising edge of vsync. Every cycle the sprite
// under (curr_x, curr_y) is composited (lowest index wins, else bg_rgb) and
// the result is registered onto draw_r/g/b.
// Ports:
//   clk, rst_n        pixel clock, async active-low reset
//   curr_x, curr_y    current active-area pixel
//   vsync             frame-start pulse (rising edge used)
//   bg_rgb            background colour {r,g,b}
//   upd               sprite update port (slave side)
//   frame_tick        one-cycle pulse on the cycle after commit
//   draw_r/g/b        composited colour, 1-cycle latency from curr_x/curr_y
//
// state  | meaning
// ACCEPT | grant at most one update request per cycle into the shadow bank
// COMMIT | one cycle: copy pending shadow entries to the active bank
module sprite_layer_arbiter
  import draw_pkg::*;
#(
  parameter int N_SPR = 4,
  parameter int SPR_W = 32,
  parameter int SPR_H = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [X_W-1:0]       curr_x,
  input  logic [Y_W-1:0]       curr_y,
  input  logic                 vsync,
  input  logic [RGB_W-1:0]     bg_rgb,
  sprite_layer_arbiter_if.slave upd,
  output logic                 frame_tick,
  output logic [3:0]           draw_r,
  output logic [3:0]           draw_g,
  output logic [3:0]           draw_b
);

  localparam int PTR_W = $clog2(N_SPR);

  state_t             state, state_nxt;
  logic [PTR_W-1:0]   rr_ptr, next_ptr;
  logic [N_SPR-1:0]   grant, pending, hit;
  logic               vsync_d, vsync_rise, grant_en, commit;
  logic [RGB_W-1:0]   pix;
  sprite_t            shadow [N_SPR];
  sprite_t            active [N_SPR];

  assign vsync_rise = vsync & ~vsync_d;

  rr_arbiter #(.N(N_SPR)) u_rr_arbiter (
    .req      (upd.upd_req),
    .ptr      (rr_ptr),
    .grant    (grant),
    .next_ptr (next_ptr)
  );

  // The ack is combinational from req so it lands in the grant cycle; rst_n
  // gates it so a requester holding req during reset sees no ack.
  assign upd.upd_ack = (grant_en && rst_n) ? grant : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_ACCEPT;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    grant_en  = 1'b0;
    commit    = 1'b0;
    case (state)
      ST_ACCEPT: begin
        if (vsync_rise) state_nxt = ST_COMMIT;
        else            grant_en  = 1'b1;
      end
      ST_COMMIT: begin
        commit    = 1'b1;
        state_nxt = ST_ACCEPT;
      end
      default: state_nxt = ST_ACCEPT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_d    <= 1'b0;
      frame_tick <= 1'b0;
      rr_ptr     <= '0;
      pending    <= '0;
      draw_r     <= '0;
      draw_g     <= '0;
      draw_b     <= '0;
      for (int i = 0; i < N_SPR; i++) begin
        shadow[i] <= '0;
        active[i] <= '0;
      end
    end else begin
      vsync_d    <= vsync;
      frame_tick <= commit;
      {draw_r, draw_g, draw_b} <= pix;
      if (grant_en && (|upd.upd_req)) rr_ptr <= next_ptr;
      // Grants and commit never share a cycle, so each entry sees at most one.
      for (int i = 0; i < N_SPR; i++) begin
        if (grant_en && grant[i]) begin
          shadow[i] <= '{x:   upd.upd_x[X_W*i +: X_W],
                         y:   upd.upd_y[Y_W*i +: Y_W],
                         rgb: upd.upd_rgb[RGB_W*i +: RGB_W],
                         vis: upd.upd_vis[i]};
          pending[i] <= 1'b1;
        end else if (commit && pending[i]) begin
          active[i]  <= shadow[i];
          pending[i] <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    hit = '0;
    for (int i = 0; i < N_SPR; i++) begin
      hit[i] = active[i].vis
             && (XS_W'(curr_x) >= XS_W'(active[i].x))
             && (XS_W'(curr_x) <  XS_W'(active[i].x) + XS_W'(SPR_W))
             && (YS_W'(curr_y) >= YS_W'(active[i].y))
             && (YS_W'(curr_y) <  YS_W'(active[i].y) + YS_W'(SPR_H));
    end
  end

  // Walk from the highest index down so the lowest hitting index is left.
  always_comb begin
    pix = bg_rgb;
    for (int i = N_SPR - 1; i >= 0; i--) begin
      if (hit[i]) pix = active[i].rgb;
    end
  end

endmodule
